// File: rtl/period_counter_trig.sv
// Period counter with one-shot triggers and a lock detector.
// Counts CLK cycles between SYNC strobes and latches the completed period
// (saturating at MAX_COUNT). It raises NCH independent one-shot triggers at
// programmed offsets into each period and asserts LOCK once consecutive
// periods have stayed within LOCK_TOL cycles of each other LOCK_CNT times.
// All outputs are registered.
module period_counter_trig #(
  parameter int unsigned W         = 16,
  parameter int unsigned MAX_COUNT = 26250,
  parameter int unsigned NCH       = 2,
  parameter int unsigned LOCK_TOL  = 2,
  parameter int unsigned LOCK_CNT  = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             SYNC,
  input  logic [NCH*W-1:0] CMP_VAL,
  input  logic [NCH-1:0]   CMP_EN,
  output logic [W-1:0]     TOL,
  output logic             TOL_VALID,
  output logic             OVF,
  output logic [NCH-1:0]   TRIG,
  output logic             LOCK
);

  localparam logic [W-1:0] MaxCnt  = W'(MAX_COUNT);
  localparam logic [W:0]   LockTol = (W+1)'(LOCK_TOL);
  localparam logic [3:0]   LockCnt = 4'(LOCK_CNT);

  // Cycle counter and latched period
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   tol_q, tol_d;
  logic           tol_valid_q, tol_valid_d;
  logic           ovf_q, ovf_d;

  // Trigger state
  logic [NCH-1:0] trig_q, trig_d;
  logic [NCH-1:0] fired_q, fired_d;
  logic [NCH-1:0] match;

  // Lock detector state
  logic [3:0]     stab_q, stab_d;
  logic [W-1:0]   prev_q, prev_d;
  logic           prev_valid_q, prev_valid_d;
  logic           lock_q, lock_d;

  // Set by the first SYNC; until then there is no period to measure
  logic           armed_q, armed_d;

  logic           at_max;
  logic           period_done;
  logic [W:0]     diff_raw;
  logic [W:0]     abs_diff;
  logic           stable;
  logic [3:0]     stab_inc;

  assign at_max      = (cnt_q == MaxCnt);
  assign period_done = SYNC & armed_q;

  // Cycle counter: restart at 1 on SYNC, otherwise count up and hold at MAX_COUNT
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q | SYNC;
    if (SYNC) begin
      cnt_d = W'(1);
    end else if (cnt_q < MaxCnt) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Period latch: capture the finished count on every armed SYNC
  always_comb begin
    tol_d       = tol_q;
    ovf_d       = ovf_q;
    tol_valid_d = 1'b0;
    if (period_done) begin
      tol_d       = cnt_q;
      ovf_d       = at_max;
      tol_valid_d = 1'b1;
    end
  end

  // Trigger compare: one pulse per channel per period, re-armed by SYNC
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      // A zero offset is never reachable once armed; guard it explicitly anyway
      match[i] = armed_q & CMP_EN[i] & ~fired_q[i] &
                 (CMP_VAL[i*W +: W] != '0) & (cnt_q == CMP_VAL[i*W +: W]);
    end
    trig_d  = match;
    fired_d = SYNC ? '0 : (fired_q | match);
  end

  // Lock detector: compare each non-overflow period against the previous one
  always_comb begin
    // Difference is taken one bit wider so the sign survives
    diff_raw = {1'b0, cnt_q} - {1'b0, prev_q};
    abs_diff = diff_raw[W] ? (~diff_raw + (W+1)'(1)) : diff_raw;
    stable   = prev_valid_q & (abs_diff <= LockTol);
    stab_inc = (stab_q < LockCnt) ? (stab_q + 4'd1) : LockCnt;

    stab_d       = stab_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    lock_d       = lock_q;
    if (period_done) begin
      if (at_max) begin
        // A saturated period says nothing about the real length
        stab_d       = 4'd0;
        lock_d       = 1'b0;
        prev_valid_d = 1'b0;
      end else begin
        stab_d       = stable ? stab_inc : 4'd0;
        prev_d       = cnt_q;
        prev_valid_d = 1'b1;
        lock_d       = (stab_d == LockCnt);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q        <= '0;
      tol_q        <= '0;
      tol_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
      trig_q       <= '0;
      fired_q      <= '0;
      stab_q       <= 4'd0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      lock_q       <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tol_q        <= tol_d;
      tol_valid_q  <= tol_valid_d;
      ovf_q        <= ovf_d;
      trig_q       <= trig_d;
      fired_q      <= fired_d;
      stab_q       <= stab_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      lock_q       <= lock_d;
      armed_q      <= armed_d;
    end
  end

  assign TOL       = tol_q;
  assign TOL_VALID = tol_valid_q;
  assign OVF       = ovf_q;
  assign TRIG      = trig_q;
  assign LOCK      = lock_q;

endmodule

// File: tb/tb_period_counter_trig.sv
// Scoreboard bench for period_counter_trig: expected TOL_VALID records and
// trigger cycles are queued as SYNCs are driven and checked as outputs appear.
module tb_period_counter_trig;

  localparam int unsigned W        = 16;
  localparam int unsigned MaxCount = 26250;
  localparam int unsigned Nch      = 2;
  localparam int unsigned LockTol  = 2;
  localparam int unsigned LockCnt  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sync = 1'b0;
  logic [Nch*W-1:0] cmp_val = '0;
  logic [Nch-1:0]   cmp_en = '0;
  logic [W-1:0]     tol;
  logic             tol_valid;
  logic             ovf;
  logic [Nch-1:0]   trig;
  logic             lock;

  always #5 clk = ~clk;

  period_counter_trig #(
    .W        (W),
    .MAX_COUNT(MaxCount),
    .NCH      (Nch),
    .LOCK_TOL (LockTol),
    .LOCK_CNT (LockCnt)
  ) dut (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .SYNC     (sync),
    .CMP_VAL  (cmp_val),
    .CMP_EN   (cmp_en),
    .TOL      (tol),
    .TOL_VALID(tol_valid),
    .OVF      (ovf),
    .TRIG     (trig),
    .LOCK     (lock)
  );

  typedef struct packed {
    int unsigned  cyc;
    logic [W-1:0] tol;
    logic         ovf;
    logic         lock;
  } tolv_t;

  tolv_t       tolv_q[$];
  int unsigned trig_q0[$];
  int unsigned trig_q1[$];
  tolv_t       mon_e;
  int unsigned mon_c;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  // Reference model of the period/lock behaviour
  bit          m_armed = 1'b0;
  bit          m_pv    = 1'b0;
  bit          m_lock  = 1'b0;
  int unsigned m_last  = 0;
  int unsigned m_prev  = 0;
  int unsigned m_stab  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) tick();
  endtask

  task automatic model_reset();
    m_armed = 1'b0;
    m_pv    = 1'b0;
    m_stab  = 0;
    m_lock  = 1'b0;
  endtask

  // Drive a one-cycle SYNC in the current cycle and queue its expected TOL_VALID
  task automatic do_sync();
    int unsigned gap;
    int unsigned d;
    tolv_t       e;
    if (m_armed) begin
      gap   = cyc - m_last;
      e.cyc = cyc + 1;
      if (gap >= MaxCount) begin
        e.tol  = W'(MaxCount);
        e.ovf  = 1'b1;
        m_stab = 0;
        m_lock = 1'b0;
        m_pv   = 1'b0;
      end else begin
        e.tol = W'(gap);
        e.ovf = 1'b0;
        d     = (gap > m_prev) ? (gap - m_prev) : (m_prev - gap);
        if (m_pv && d <= LockTol) m_stab = (m_stab < LockCnt) ? m_stab + 1 : LockCnt;
        else m_stab = 0;
        m_prev = gap;
        m_pv   = 1'b1;
        m_lock = (m_stab == LockCnt);
      end
      e.lock = m_lock;
      tolv_q.push_back(e);
    end
    m_armed = 1'b1;
    m_last  = cyc;
    sync    = 1'b1;
    tick();
    sync    = 1'b0;
  endtask

  // SYNC now, then p-1 idle cycles; queue the triggers this period should produce
  task automatic run_period(input int unsigned p);
    int unsigned c;
    int unsigned v0;
    int unsigned v1;
    c  = cyc;
    v0 = cmp_val[0 +: W];
    v1 = cmp_val[W +: W];
    do_sync();
    if (cmp_en[0] && v0 >= 1 && v0 <= MaxCount && v0 <= p) trig_q0.push_back(c + v0 + 1);
    if (cmp_en[1] && v1 >= 1 && v1 <= MaxCount && v1 <= p) trig_q1.push_back(c + v1 + 1);
    idle(p - 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tol"}, 32'(tol), 0);
    check({tag, "_tolv"}, 32'(tol_valid), 0);
    check({tag, "_ovf"}, 32'(ovf), 0);
    check({tag, "_trig"}, 32'(trig), 0);
    check({tag, "_lock"}, 32'(lock), 0);
  endtask

  // Output monitor: every pulse must match the head of its queue
  always @(negedge clk) begin
    if (tol_valid) begin
      check("tolv_pending", 32'(tolv_q.size() > 0), 1);
      if (tolv_q.size() > 0) begin
        mon_e = tolv_q.pop_front();
        check("tolv_cycle", cyc, mon_e.cyc);
        check("tol", 32'(tol), 32'(mon_e.tol));
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
        check("lock", 32'(lock), 32'(mon_e.lock));
      end
    end
    if (trig[0]) begin
      check("trig0_pending", 32'(trig_q0.size() > 0), 1);
      if (trig_q0.size() > 0) begin
        mon_c = trig_q0.pop_front();
        check("trig0_cycle", cyc, mon_c);
      end
    end
    if (trig[1]) begin
      check("trig1_pending", 32'(trig_q1.size() > 0), 1);
      if (trig_q1.size() > 0) begin
        mon_c = trig_q1.pop_front();
        check("trig1_cycle", cyc, mon_c);
      end
    end
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    model_reset();
    idle(2);

    // First SYNC only arms
    do_sync();
    @(negedge clk);
    check("first_sync_tolv", 32'(tol_valid), 0);
    check("first_sync_tol", 32'(tol), 0);
    idle(799);
    for (int k = 0; k < 3; k++) run_period(800);

    // Triggers at offsets 100 and 799
    cmp_val[0 +: W] = W'(100);
    cmp_val[W +: W] = W'(799);
    cmp_en = 2'b11;
    run_period(800);
    run_period(800);
    cmp_en = 2'b01;
    run_period(800);

    // Saturated period with a trigger at MAX_COUNT
    cmp_val[0 +: W] = W'(MaxCount);
    run_period(30000);
    cmp_en = 2'b00;
    run_period(800);
    check("sat_tol", 32'(tol), MaxCount);
    check("sat_ovf", 32'(ovf), 1);
    check("sat_lock", 32'(lock), 0);

    // Lock acquisition and loss
    run_period(801);
    run_period(799);
    run_period(800);
    run_period(802);
    run_period(805);
    check("lock_up", 32'(lock), 1);
    run_period(800);
    check("lock_down", 32'(lock), 0);
    for (int k = 0; k < 5; k++) run_period(800);

    // Mid-period reset while locked
    do_sync();
    idle(399);
    check("pre_reset_lock", 32'(lock), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_all_zero("mid_reset");
    idle(50);
    do_sync();
    @(negedge clk);
    check("rearm_tolv", 32'(tol_valid), 0);
    idle(599);
    do_sync();
    @(negedge clk);
    check("rearm_tol", 32'(tol), 600);

    // Back-to-back SYNC
    idle(9);
    do_sync();
    do_sync();
    @(negedge clk);
    check("b2b_tolv", 32'(tol_valid), 1);
    check("b2b_tol", 32'(tol), 1);

    idle(20);
    check("tolv_left", tolv_q.size(), 0);
    check("trig0_left", trig_q0.size(), 0);
    check("trig1_left", trig_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/period_counter_trig.md
# period_counter_trig

Parametrised line/frame period counter for the VGA/D8M timing path. It counts CLK cycles between successive SYNC strobes and latches the completed period, saturating at a programmable maximum. It generates NCH independently programmable one-shot trigger pulses at chosen offsets into each period. It also reports a LOCK flag once the measured period has been stable for a programmable number of periods. It sits beside the VGA controller, fed by the incoming sync strobe, and supplies period and trigger information to downstream timing logic.

## Interface
- W, 16: counter, period and compare width; must satisfy MAX_COUNT < 2^W.
- MAX_COUNT, 26250: saturation value of the cycle counter (50*525).
- NCH, 2: number of trigger channels, 1..8.
- LOCK_TOL, 2: maximum absolute difference, in cycles, between consecutive periods counted as stable.
- LOCK_CNT, 4: consecutive stable comparisons required to assert LOCK, 1..15.

Ports:
- CLK  in  1  sole clock; all logic on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- SYNC  in  1  period boundary strobe, sampled every cycle.
- CMP_VAL  in  NCH*W  packed compare offsets; channel i occupies bits [i*W +: W].
- CMP_EN  in  NCH  per-channel trigger enable.
- TOL  out  W  last completed period length in cycles.
- TOL_VALID  out  1  one-cycle pulse when TOL/OVF are updated.
- OVF  out  1  last completed period hit MAX_COUNT.
- TRIG  out  NCH  per-channel one-cycle trigger pulses.
- LOCK  out  1  period stable.

## Operation
- Reset (RESET_N=0 at a clock edge) clears CNT, TOL, TOL_VALID, OVF, TRIG, LOCK, the stability counter, the previous-period register, the fired mask and the armed flag to 0. This holds at any point mid-operation.
- Armed flag: set by the first SYNC after reset. That SYNC restarts CNT but produces no TOL_VALID and changes neither TOL nor the lock state.
- Counter:
  - On SYNC, CNT <= 1.
  - Otherwise, if CNT < MAX_COUNT, CNT <= CNT+1.
  - Otherwise CNT holds at MAX_COUNT.
  - As a result, CNT = k in the k-th cycle after a SYNC cycle, and SYNC every P cycles gives TOL = P.
- Period latch (SYNC while armed):
  - TOL <= CNT.
  - OVF <= (CNT == MAX_COUNT).
  - TOL_VALID <= 1 for one cycle.
- Triggers:
  - TRIG[i] <= armed & CMP_EN[i] & (CNT == CMP_VAL[i]) & ~fired[i].
  - fired[i] is set on a match and cleared on SYNC. Each channel therefore fires at most once per period, including while CNT is saturated.
  - CMP_VAL[i] = 0 or CMP_VAL[i] > MAX_COUNT never fires.
  - If a match and SYNC occur in the same cycle, TRIG fires and fired[i] ends cleared for the new period.
- Lock, evaluated on each armed SYNC:
  - If OVF would be 1: stability counter <= 0, LOCK <= 0, and the previous-period register is marked invalid.
  - Else, if the previous period is valid and |CNT - prev| <= LOCK_TOL (difference computed in W+1 bits): stability counter increments, saturating at LOCK_CNT.
  - Else: stability counter <= 0.
  - In every non-overflow case, prev <= CNT and is marked valid.
  - LOCK <= (next stability counter == LOCK_CNT).
- CMP_VAL and CMP_EN may change at any time and take effect on the next compare.

## Timing
- TOL, OVF, TOL_VALID and LOCK update together, one cycle after the SYNC cycle.
- TRIG[i] is registered. For SYNC in cycle 0, TRIG[i] is high in cycle CMP_VAL[i]+1.
- Back-to-back SYNC in cycles 0 and 1 gives TOL = 1 with two consecutive TOL_VALID pulses.
- A SYNC held high for multiple cycles is treated as repeated period-1 strobes; no edge detection is performed.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then SYNC every 800 cycles: first SYNC gives no TOL_VALID and TOL=0. Each subsequent SYNC gives a TOL_VALID pulse with TOL=800 and OVF=0.
- CMP_VAL={799,100}, CMP_EN=2'b11, period 800, SYNC at cycle 0: TRIG[0] high only in cycle 101, TRIG[1] high only in cycle 800. With CMP_EN=2'b01, TRIG[1] stays 0.
- SYNC gap 30000, MAX_COUNT=26250, CMP_VAL[0]=26250: TOL=26250, OVF=1, LOCK=0. TRIG[0] pulses exactly once.
- Periods 800, 801, 799, 800, 802: LOCK rises with the 5th TOL_VALID. A following period of 805 drops LOCK with that TOL_VALID.
- RESET_N low for one cycle at CNT=400 while LOCK=1: all outputs 0 the next cycle. The next SYNC gives no TOL_VALID, and the SYNC after that gives TOL equal to its gap.
- SYNC high in two consecutive cycles: the second TOL_VALID carries TOL=1.
